intdiv_otf: RTL and testbench

- Consumer end of the SD2 quotient-digit stream of the non-restoring integer divider.
- Accepts one SD2 quotient digit per cycle, MSB first, and converts on the fly to two's complement using the Q / QM register pair.
- Then takes the padj/seladj correction decision from the divider's final-adjust stage and applies it to produce the final N-bit quotient.
- Sits between the divider iteration array and the result register / bus interface.

---
 rtl/intdiv_otf_if.sv | 29 ++
 rtl/intdiv_otf.sv | 124 ++++++++++++
 tb/tb_intdiv_otf.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/intdiv_otf_if.sv
// Handshake bundle for the on-the-fly SD2 -> two's-complement quotient converter.
// master: digit/adjust producer + result consumer side (drives start, digits,
//         adjustment decision, q_ack).
// slave : the converter (drives ready strobes, result, busy, ovf).
interface intdiv_otf_if #(parameter int N = 16);
  logic         start;
  logic         digit_valid;
  logic [1:0]   digit;
  logic         digit_ready;
  logic         adj_valid;
  logic         padj;
  logic         seladj;
  logic         adj_ready;
  logic [N-1:0] q_out;
  logic         q_valid;
  logic         q_ack;
  logic         busy;
  logic         ovf;

  modport master (
    output start, digit_valid, digit, adj_valid, padj, seladj, q_ack,
    input  digit_ready, adj_ready, q_out, q_valid, busy, ovf
  );

  modport slave (
    input  start, digit_valid, digit, adj_valid, padj, seladj, q_ack,
    output digit_ready, adj_ready, q_out, q_valid, busy, ovf
  );
endinterface

// File: rtl/intdiv_otf.sv
// intdiv_otf: consumer end of the non-restoring divider's SD2 quotient stream.
// Takes N SD2 digits MSB first, converts on the fly with the Q/QM pair
// (QM == Q-1 always), then applies the final padj/seladj correction.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : start, digit_valid/digit/digit_ready, adj_valid/padj/
//                   seladj/adj_ready, q_out/q_valid/q_ack, busy, ovf
// Build option: define INTDIV_OTF_OVF_EN to get wrap detection on ovf;
// otherwise ovf is tied low.
module intdiv_otf #(
  parameter int N = 16
) (
  input logic        clk,
  input logic        rst,
  intdiv_otf_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, ADJ = 2'd2, DONE = 2'd3} state_t;

  state_t         state, nxt;
  logic [N-1:0]   q, qm, q_res, q_out_r;
  logic [CW-1:0]  cnt;
  logic           dig_acc, adj_acc, last_dig;
  logic           d_neg, d_pos;

  // 11 = -1, 01/10 = +1, 00 = 0
  assign d_neg    = (bus.digit == 2'b11);
  assign d_pos    = bus.digit[1] ^ bus.digit[0];
  assign last_dig = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt             = state;
    bus.digit_ready = 1'b0;
    bus.adj_ready   = 1'b0;
    bus.q_valid     = 1'b0;
    bus.busy        = 1'b1;
    dig_acc         = 1'b0;
    adj_acc         = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) nxt = ACC;
      end
      ACC: begin
        bus.digit_ready = 1'b1;
        dig_acc         = bus.digit_valid;
        if (dig_acc && last_dig) nxt = ADJ;
      end
      ADJ: begin
        // not ready while the last digit is being taken, so an early
        // adj_valid simply waits one cycle
        bus.adj_ready = 1'b1;
        adj_acc       = bus.adj_valid;
        if (adj_acc) nxt = DONE;
      end
      DONE: begin
        bus.q_valid = 1'b1;
        if (bus.q_ack) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Correction: Q as is, Q-1 (already held in QM), or Q+1 with carry dropped
  always_comb begin
    if (bus.seladj)    q_res = q;
    else if (bus.padj) q_res = q + N'(1);
    else               q_res = qm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      qm      <= '1;
      cnt     <= '0;
      q_out_r <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        q   <= '0;
        qm  <= '1;
        cnt <= '0;
      end
      if (dig_acc) begin
        cnt <= cnt + CW'(1);
        // a -1 digit borrows from the prefix, so the new Q comes from QM
        if (d_neg) begin
          q  <= {qm[N-2:0], 1'b1};
          qm <= {qm[N-2:0], 1'b0};
        end else if (d_pos) begin
          q  <= {q[N-2:0], 1'b1};
          qm <= {q[N-2:0], 1'b0};
        end else begin
          q  <= {q[N-2:0], 1'b0};
          qm <= {qm[N-2:0], 1'b1};
        end
      end
      if (adj_acc) q_out_r <= q_res;
    end
  end

  assign bus.q_out = q_out_r;

`ifdef INTDIV_OTF_OVF_EN
  logic ovf_r, ovf_nxt;
  // increment of all-ones or decrement of zero wraps
  assign ovf_nxt = !bus.seladj && (bus.padj ? (&q) : (q == '0));

  always_ff @(posedge clk) begin
    if (rst)                             ovf_r <= 1'b0;
    else if (adj_acc)                    ovf_r <= ovf_nxt;
    else if (state == DONE && bus.q_ack) ovf_r <= 1'b0;
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_intdiv_otf.sv
// Bench for intdiv_otf (N=4): directed test-plan runs plus random runs.
// Driver pushes the expected result when the adjustment is issued; a
// monitor pops and compares on every rising q_valid.
module tb_intdiv_otf;
  localparam int N = 4;
  typedef int dig_t[N];

  typedef struct {
    logic [N-1:0] q;
    logic         ovf;
    int           st;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intdiv_otf_if #(.N(N)) bus();
  intdiv_otf #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one comparison set per result
  logic qv_d = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (bus.q_valid === 1'b1 && !qv_d) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(bus.q_valid), 32'd0);
      end else begin
        me = sb.pop_front();
        chk("q_out", 32'(bus.q_out), 32'(me.q));
        chk("ovf", 32'(bus.ovf), 32'(me.ovf));
        chk("latency", 32'(cyc - me.st), 32'(me.lat));
      end
    end
    qv_d = (bus.q_valid === 1'b1);
  end

  function automatic logic [1:0] enc(input int d);
    if (d < 0)  return 2'b11;
    if (d == 0) return 2'b00;
    return ($urandom % 2) ? 2'b01 : 2'b10;
  endfunction

  // Reference: digit string value by plain arithmetic, then the correction
  function automatic exp_t model(input dig_t d, input bit sel, input bit padj);
    exp_t e;
    int v = 0;
    logic [N-1:0] qv;
    for (int i = 0; i < N; i++) v = v * 2 + d[i];
    qv = N'(v);
    if (sel)       e.q = qv;
    else if (padj) e.q = N'(v + 1);
    else           e.q = N'(v - 1);
`ifdef INTDIV_OTF_OVF_EN
    e.ovf = !sel && (padj ? (v % (1 << N) == -1 || qv == '1) : (qv == '0));
`else
    e.ovf = 1'b0;
`endif
    e.st = 0;
    e.lat = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the given ready is high, then let the edge take the item
  task automatic wait_ready(input bit is_adj, input string name);
    int t = 0;
    while (((is_adj ? bus.adj_ready : bus.digit_ready) !== 1'b1) && t < 50) begin
      step();
      t++;
    end
    if (t == 50) chk({name, "_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  task automatic run(input dig_t d, input int gap, input bit sel, input bit padj,
                     input bit early, input int hold);
    exp_t e;
    e = model(d, sel, padj);
    e.lat = N + 2 + gap;
    e.st = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == N / 2)
        for (int g = 0; g < gap; g++) begin
          bus.digit_valid = 1'b0;
          bus.digit = 2'b11;
          step();
        end
      bus.digit_valid = 1'b1;
      bus.digit = enc(d[i]);
      if (i == N - 1 && early) begin
        bus.adj_valid = 1'b1;
        bus.seladj = sel;
        bus.padj = padj;
        chk("adj_ready_with_last_digit", 32'(bus.adj_ready), 32'd0);
      end
      wait_ready(1'b0, "digit");
    end
    bus.digit_valid = 1'b0;
    bus.adj_valid = 1'b1;
    bus.seladj = sel;
    bus.padj = padj;
    sb.push_back(e);
    wait_ready(1'b1, "adj");
    bus.adj_valid = 1'b0;
    bus.seladj = $urandom % 2;
    bus.padj = $urandom % 2;
    // result must hold without q_ack; start meanwhile is ignored
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      @(negedge clk);
      chk("hold_q_valid", 32'(bus.q_valid), 32'd1);
      chk("hold_q_out", 32'(bus.q_out), 32'(e.q));
      step();
    end
    bus.start = 1'b0;
    bus.q_ack = 1'b1;
    step();
    bus.q_ack = 1'b0;
    chk("q_valid_after_ack", 32'(bus.q_valid), 32'd0);
    chk("busy_after_ack", 32'(bus.busy), 32'd0);
    chk("ovf_after_ack", 32'(bus.ovf), 32'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_q_valid"}, 32'(bus.q_valid), 32'd0);
    chk({name, "_q_out"}, 32'(bus.q_out), 32'd0);
    chk({name, "_ovf"}, 32'(bus.ovf), 32'd0);
    chk({name, "_digit_ready"}, 32'(bus.digit_ready), 32'd0);
    chk({name, "_adj_ready"}, 32'(bus.adj_ready), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dig_t d;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit = 2'b00;
    bus.adj_valid = 1'b0;
    bus.padj = 1'b0;
    bus.seladj = 1'b0;
    bus.q_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk_idle("reset");

    // directed test-plan runs
    run('{1, -1, 1, 1}, 0, 1'b1, 1'b0, 1'b0, 0);   // 0111
    chk("qm_internal", 32'(dut.qm), 32'h6);
    run('{0, 1, 0, -1}, 0, 1'b0, 1'b0, 1'b0, 1);   // 0010
    run('{0, 1, 0, -1}, 0, 1'b0, 1'b1, 1'b0, 0);   // 0100
    run('{-1, 0, 0, 1}, 0, 1'b1, 1'b0, 1'b0, 0);   // 1001
    run('{-1, 0, 0, 1}, 2, 1'b1, 1'b0, 1'b0, 0);   // 1001, two cycles later
    run('{1, 1, 1, 1}, 0, 1'b0, 1'b1, 1'b0, 0);    // 0000, wrap
    run('{0, 0, 0, 0}, 0, 1'b0, 1'b0, 1'b0, 0);    // 1111, wrap
    run('{1, 0, 1, -1}, 0, 1'b1, 1'b0, 1'b1, 3);   // early adj, 3-cycle hold

    // abort after two digits, then rst together with start
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.digit_valid = 1'b1;
    bus.digit = 2'b01;
    repeat (2) step();
    bus.digit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("abort");
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_beats_start", 32'(bus.busy), 32'd0);
    // inputs other than start are ignored in IDLE
    bus.digit_valid = 1'b1;
    bus.digit = 2'b01;
    bus.adj_valid = 1'b1;
    bus.q_ack = 1'b1;
    repeat (2) step();
    bus.digit_valid = 1'b0;
    bus.adj_valid = 1'b0;
    bus.q_ack = 1'b0;
    chk("idle_ignores_inputs", 32'(bus.busy), 32'd0);
    run('{1, 0, 0, 0}, 0, 1'b1, 1'b0, 1'b0, 0);    // 1000

    // random runs
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 2)) - 1;
      run(d, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
          1'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (2) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
